branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  XLEN, 32, address width
  ENTRIES, 64, BTB and counter-table depth; power of two, 4..1024
  GHR_BITS, 6, global history length; 0 = bimodal mode, >0 = gshare mode
  CTR_BITS, 2, saturating-counter width, 1..4
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  pred_pc  in  XLEN  fetch PC to predict
  pred_taken  out  1  predict redirect
  pred_target  out  XLEN  next PC: BTB target if pred_taken, else pred_pc+4
  pred_hit  out  1  BTB tag hit
  upd_valid  in  1  resolved control-transfer instruction this cycle
  upd_pc  in  XLEN  PC of resolved instruction
  upd_is_jump  in  1  1 = unconditional jump, 0 = conditional branch
  upd_taken  in  1  actual outcome
  upd_target  in  XLEN  actual target
  upd_pred_taken  in  1  prediction previously given for this instruction
  perf_lookups  out  32  count of cycles with upd_valid
  perf_mispredicts  out  32  count of mispredictions

Function
REQ-003 SHALL form index = pc[IDX+1:2] XOR ghr (zero-extended, or truncated to IDX bits), IDX = log2(ENTRIES); ghr term is 0 when GHR_BITS=0.
REQ-004 SHALL form BTB index = pc[IDX+1:2] (no history) and tag = pc[XLEN-1:IDX+2].
REQ-005 SHALL form the lookup combinationally from registered state, zero cycle latency: pred_hit = valid & tag match; pred_taken = pred_hit & (is_jump | counter MSB).
REQ-006 SHALL update state on the clk edge where upd_valid=1; state SHALL NOT change when upd_valid=0.
REQ-007 SHALL update the counter at index(upd_pc) only when upd_is_jump=0: increment if taken, decrement if not, saturating at 0 and 2^CTR_BITS-1.
REQ-008 SHALL write the BTB entry (valid=1, tag, target, is_jump) when upd_taken=1; an existing entry SHALL be replaced on tag mismatch; upd_taken=0 SHALL leave the BTB unchanged.
REQ-009 SHALL shift upd_taken into the LSB of ghr only for conditional branches (upd_is_jump=0).
REQ-010 SHALL return pre-update state when a lookup and an update hit the same index in the same cycle (no bypass).
REQ-011 SHALL count a misprediction when upd_valid & (upd_taken != upd_pred_taken); perf counters SHALL saturate at 32'hFFFF_FFFF.
REQ-012 SHALL compute pred_pc+4 and all index arithmetic modulo 2^XLEN (wraps at the top address).

Reset
REQ-013 SHALL, while reset=0, asynchronously clear all BTB valid bits, ghr and both perf counters, and set every counter to weakly-not-taken (2^(CTR_BITS-1)-1).
REQ-014 SHALL therefore drive pred_hit=0, pred_taken=0 and pred_target=pred_pc+4 during and right after reset; an update asserted during reset SHALL be ignored.

Structure
REQ-015 SHALL take parameter defaults, the counter reset value and the BTB entry struct (valid, tag, target, is_jump) from a shared package bpu_pkg.
REQ-016 SHALL place BTB storage and tag compare in one sub-module bpu_btb; counters, ghr and perf counters SHALL stay in the top.

Verification
REQ-017 SHALL cover reset: ENTRIES=16; after reset release, pred_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-018 SHALL cover training (GHR_BITS=0): two taken updates of pc 0x100, target 0x80 -> pred_taken=1, pred_target=0x80; then three not-taken updates -> pred_taken=0, pred_hit=1.
REQ-019 SHALL cover jumps: one update of pc 0x200, upd_is_jump=1, target 0x400 -> pred_taken=1 immediately; ghr unchanged.
REQ-020 SHALL cover aliasing (ENTRIES=16): taken update of 0x100 then 0x140 -> lookup 0x100 gives pred_hit=0.
REQ-021 SHALL cover same-cycle lookup/update of 0x100 -> old prediction that cycle, new prediction next cycle; mispredicting update -> perf_mispredicts+1.
REQ-022 SHALL cover saturation: at least 5 taken updates leave the counter at 3, and one not-taken update still predicts taken.

Source files
------------

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared defaults, counter reset value and BTB entry type for the branch predictor
package bpu_pkg;

   localparam int XLEN_D     = 32;
   localparam int ENTRIES_D  = 64;
   localparam int GHR_BITS_D = 6;
   localparam int CTR_BITS_D = 2;

   // BTB fields are sized for the widest supported address; narrower XLEN zero-extends into them.
   typedef struct packed {
      logic              valid;
      logic [XLEN_D-1:0] tag;
      logic [XLEN_D-1:0] target;
      logic              is_jump;
   } btb_entry_t;

   function automatic int ctr_reset_val(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

endpackage

// File: rtl/bpu_btb.sv
// rtl/bpu_btb.sv - direct-mapped branch target buffer with combinational tag compare
module bpu_btb
   import bpu_pkg::*;
#(
   parameter int XLEN    = XLEN_D,
   parameter int ENTRIES = ENTRIES_D
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            hit,
   output logic [XLEN-1:0] target,
   output logic            is_jump,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_pc,
   input  logic [XLEN-1:0] wr_target,
   input  logic            wr_is_jump
);

   localparam int IDX = $clog2(ENTRIES);

   btb_entry_t        mem [ENTRIES];
   btb_entry_t        ent;
   logic [IDX-1:0]    l_idx, w_idx;
   logic [XLEN_D-1:0] l_tag, w_tag;
   logic              unused_lo;

   assign l_idx     = lookup_pc[IDX+1:2];
   assign w_idx     = wr_pc[IDX+1:2];
   assign l_tag     = XLEN_D'(lookup_pc[XLEN-1:IDX+2]);
   assign w_tag     = XLEN_D'(wr_pc[XLEN-1:IDX+2]);
   assign unused_lo = ^{lookup_pc[1:0], wr_pc[1:0]};

   assign ent     = mem[l_idx];
   assign hit     = ent.valid && (ent.tag == l_tag);
   assign target  = ent.target[XLEN-1:0];
   assign is_jump = ent.is_jump;

   // A write always claims the slot, so a different tag simply evicts the old entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[w_idx].valid   <= 1'b1;
         mem[w_idx].tag     <= w_tag;
         mem[w_idx].target  <= XLEN_D'(wr_target);
         mem[w_idx].is_jump <= wr_is_jump;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare direction predictor with BTB and perf counters
module branch_predictor
   import bpu_pkg::*;
#(
   parameter int XLEN     = XLEN_D,
   parameter int ENTRIES  = ENTRIES_D,
   parameter int GHR_BITS = GHR_BITS_D,
   parameter int CTR_BITS = CTR_BITS_D
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   output logic            pred_hit,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   output logic [31:0]     perf_lookups,
   output logic [31:0]     perf_mispredicts
);

   localparam int IDX = $clog2(ENTRIES);
   localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;
   localparam int GL  = (GHR_BITS < IDX) ? GHR_BITS : IDX;
   localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));

   logic [CTR_BITS-1:0] ctr [ENTRIES];
   logic [GW-1:0]       ghr;
   logic [IDX-1:0]      ghr_idx, p_idx, u_idx;
   logic                btb_hit, btb_jump;
   logic [XLEN-1:0]     btb_target;

   generate
      if (GL > 0) begin : g_hist
         assign ghr_idx = IDX'(ghr[GL-1:0]);
      end else begin : g_nohist
         assign ghr_idx = '0;
      end
   endgenerate

   assign p_idx = pred_pc[IDX+1:2] ^ ghr_idx;
   assign u_idx = upd_pc[IDX+1:2] ^ ghr_idx;

   bpu_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES)) u_btb (
      .clk        (clk),
      .reset      (reset),
      .lookup_pc  (pred_pc),
      .hit        (btb_hit),
      .target     (btb_target),
      .is_jump    (btb_jump),
      .wr_en      (upd_valid && upd_taken),
      .wr_pc      (upd_pc),
      .wr_target  (upd_target),
      .wr_is_jump (upd_is_jump)
   );

   // Lookup reads only registered state, so a same-cycle update is seen next cycle.
   assign pred_hit    = btb_hit;
   assign pred_taken  = btb_hit && (btb_jump || ctr[p_idx][CTR_BITS-1]);
   assign pred_target = pred_taken ? btb_target : pred_pc + XLEN'(4);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RST;
      end else if (upd_valid && !upd_is_jump) begin
         if (upd_taken && (ctr[u_idx] != '1))
            ctr[u_idx] <= ctr[u_idx] + 1'b1;
         else if (!upd_taken && (ctr[u_idx] != '0))
            ctr[u_idx] <= ctr[u_idx] - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ghr <= '0;
      else if ((GHR_BITS > 0) && upd_valid && !upd_is_jump)
         ghr <= GW'({ghr, upd_taken});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_lookups     <= '0;
         perf_mispredicts <= '0;
      end else if (upd_valid) begin
         if (perf_lookups != '1)
            perf_lookups <= perf_lookups + 32'd1;
         if ((upd_taken != upd_pred_taken) && (perf_mispredicts != '1))
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pred_pc;
   logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target;

   logic        pred_taken, pred_hit;
   logic [31:0] pred_target, perf_lookups, perf_mispredicts;
   logic        g_taken, g_hit;
   logic [31:0] g_target, g_lookups, g_mispredicts;

   int          ntest = 0;
   int          nfail = 0;
   int          exp_lookups = 0;
   int          exp_misp = 0;
   logic [3:0]  exp_ghr = 4'd0;
   logic [31:0] misp_before;

   always #5 clk = ~clk;

   branch_predictor #(.XLEN(32), .ENTRIES(16), .GHR_BITS(0), .CTR_BITS(2)) dut (
      .clk(clk), .reset(reset), .pred_pc(pred_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
   );

   // Gshare instance sharing the same stimulus, used to observe history behaviour.
   branch_predictor #(.XLEN(32), .ENTRIES(16), .GHR_BITS(4), .CTR_BITS(2)) u_g (
      .clk(clk), .reset(reset), .pred_pc(pred_pc),
      .pred_taken(g_taken), .pred_target(g_target), .pred_hit(g_hit),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .perf_lookups(g_lookups), .perf_mispredicts(g_mispredicts)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic j, input logic t,
                      input logic [31:0] tg, input logic pt);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_is_jump    = j;
      upd_taken      = t;
      upd_target     = tg;
      upd_pred_taken = pt;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      exp_lookups++;
      if (t != pt) exp_misp++;
      if (!j) exp_ghr = {exp_ghr[2:0], t};
   endtask

   initial begin
      // Update held high during reset must have no effect.
      reset          = 1'b0;
      pred_pc        = 32'h100;
      upd_valid      = 1'b1;
      upd_pc         = 32'h100;
      upd_is_jump    = 1'b0;
      upd_taken      = 1'b1;
      upd_target     = 32'h80;
      upd_pred_taken = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hit",    32'(pred_hit), 32'd0);
      check("rst_taken",  32'(pred_taken), 32'd0);
      check("rst_target", pred_target, 32'h104);
      check("rst_misp",   perf_mispredicts, 32'd0);
      upd_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_hit",    32'(pred_hit), 32'd0);
      check("post_rst_taken",  32'(pred_taken), 32'd0);
      check("post_rst_target", pred_target, 32'h104);
      check("post_rst_lookups", perf_lookups, 32'd0);
      check("post_rst_ctr",    32'(dut.ctr[0]), 32'd1);
      check("post_rst_ghr",    32'(u_g.ghr), 32'd0);

      // Training: weakly-not-taken -> strongly taken, then back down.
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1);
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1);
      check("train_taken",  32'(pred_taken), 32'd1);
      check("train_target", pred_target, 32'h80);
      repeat (3) upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
      check("untrain_taken",  32'(pred_taken), 32'd0);
      check("untrain_hit",    32'(pred_hit), 32'd1);
      check("untrain_target", pred_target, 32'h104);

      // Idle cycles with garbage on the update bus must not change anything.
      upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h999;
      repeat (4) @(posedge clk);
      #1;
      check("idle_ctr",     32'(dut.ctr[0]), 32'd0);
      check("idle_lookups", perf_lookups, 32'(exp_lookups));

      // Saturation.
      repeat (5) upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1);
      check("sat_ctr", 32'(dut.ctr[0]), 32'd3);
      upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
      check("sat_nt_taken", 32'(pred_taken), 32'd1);

      // Same-cycle lookup and mispredicting update (counter 2 -> 1).
      misp_before    = perf_mispredicts;
      pred_pc        = 32'h100;
      upd_valid      = 1'b1;
      upd_pc         = 32'h100;
      upd_is_jump    = 1'b0;
      upd_taken      = 1'b0;
      upd_target     = 32'h80;
      upd_pred_taken = 1'b1;
      #1;
      check("same_cycle_old", 32'(pred_taken), 32'd1);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      exp_lookups++;
      exp_misp++;
      exp_ghr = {exp_ghr[2:0], 1'b0};
      check("same_cycle_new", 32'(pred_taken), 32'd0);
      check("misp_delta",     perf_mispredicts - misp_before, 32'd1);

      // Unconditional jump: immediately taken, history untouched.
      upd(32'h200, 1'b1, 1'b1, 32'h400, 1'b1);
      pred_pc = 32'h200;
      #1;
      check("jump_taken",  32'(pred_taken), 32'd1);
      check("jump_target", pred_target, 32'h400);
      check("jump_ghr",    32'(u_g.ghr), 32'(exp_ghr));
      check("jump_ctr",    32'(dut.ctr[0]), 32'd1);

      // Aliasing: 0x100 and 0x140 share a BTB slot with different tags.
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1);
      upd(32'h140, 1'b0, 1'b1, 32'h90, 1'b1);
      pred_pc = 32'h100;
      #1;
      check("alias_hit_100", 32'(pred_hit), 32'd0);
      pred_pc = 32'h140;
      #1;
      check("alias_hit_140",    32'(pred_hit), 32'd1);
      check("alias_target_140", pred_target, 32'h90);

      // Fall-through wraps at the top of the address space.
      pred_pc = 32'hFFFF_FFFC;
      #1;
      check("wrap_target", pred_target, 32'h0);

      check("final_lookups", perf_lookups, 32'(exp_lookups));
      check("final_misp",    perf_mispredicts, 32'(exp_misp));
      check("final_ghr",     32'(u_g.ghr), 32'(exp_ghr));

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
